pc_ir_unit: RTL and testbench
=============================

PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 PCWrite  input  1  unconditional PC load enable from the control FSM.
REQ-005 PCWriteCond  input  1  conditional PC load enable for beq/bne.
REQ-006 PCSource1, PCSource0  input  1 each  next-PC source select.
REQ-007 IRWrite  input  1  instruction register load enable.
REQ-008 mem_rdata  input  32  memory read data.
REQ-009 alu_result  input  32  combinational ALU output.
REQ-010 alu_zero  input  1  ALU zero flag.
REQ-011 rs_data, rt_data  input  32 each  register-file read ports.
REQ-012 pc  output  32  current program counter.
REQ-013 ir  output  32  instruction register; opcode output 6 bits = ir[31:26].
REQ-014 mdr  output  32  memory data register.
REQ-015 alu_out  output  32  ALUOut register.
REQ-016 a_reg, b_reg  output  32 each  latched rs/rt operands.
REQ-017 branch_taken  output  1  one-cycle pulse, conditional branch taken.
REQ-018 instr_count  output  32  fetched-instruction counter.

Function
REQ-019 Next-PC select {PCSource1,PCSource0}: 00 alu_result; 01 alu_out; 10 jump target {pc[31:28], ir[25:0], 2'b00}; 11 current pc (no change).
REQ-020 Branch condition: ir[31:26]=000100 -> alu_zero; 000101 -> ~alu_zero; any other opcode -> 0.
REQ-021 PC load enable = PCWrite OR (PCWriteCond AND branch condition); PC updates on the same edge.
REQ-022 PCWrite and PCWriteCond both high: PC loads unconditionally; the branch condition is ignored for the load.
REQ-023 IR loads mem_rdata on an edge with IRWrite=1; otherwise holds.
REQ-024 mdr, a_reg, b_reg and alu_out load mem_rdata, rs_data, rt_data and alu_result on every edge, with no enable.
REQ-025 Jump target uses pc as registered at the time of the Jump cycle, i.e. the already-incremented PC+4.
REQ-026 branch_taken is 1 for exactly the cycle after an edge with PCWriteCond=1, PCWrite=0 and branch condition true; otherwise 0.
REQ-027 instr_count increments by 1 on each edge with IRWrite=1 and wraps from 32'hFFFF_FFFF to 0.
REQ-028 Simultaneous IRWrite and PC load: both occur on the same edge. The jump target and branch condition use the pre-edge ir.
REQ-029 All outputs are registered, except opcode, which is a direct slice of ir.

Reset
REQ-030 On an edge with rst=1: pc=RESET_PC; ir, mdr, alu_out, a_reg, b_reg, instr_count=0; branch_taken=0.
REQ-031 rst has priority over all enables. A reset mid-instruction discards any pending PC, IR or counter update in that cycle.
REQ-032 With rst=0, the first edge after release behaves normally, with no extra dead cycle.

Verification
REQ-033 Fetch: rst released, PCWrite=1, IRWrite=1, source=00, alu_result=4, mem_rdata=32'h2009_0005 -> pc=4, ir=32'h2009_0005, instr_count=1.
REQ-034 beq taken: ir opcode 000100, alu_out=32'h40, PCWriteCond=1, source=01, alu_zero=1 -> pc=32'h40 and branch_taken=1 for one cycle. With alu_zero=0 -> pc unchanged, branch_taken=0.
REQ-035 bne: opcode 000101, alu_zero=0 -> pc=alu_out. alu_zero=1 -> no load. Opcode 100011 with PCWriteCond=1 -> no load.
REQ-036 Jump: pc=32'h1000_0004, ir=32'h0800_0010, PCWrite=1, source=10 -> pc=32'h1000_0040.
REQ-037 Boundaries: instr_count preset to 32'hFFFF_FFFF plus IRWrite -> 0. Source=11 with PCWrite=1 -> pc holds.
REQ-038 Reset priority: rst=1 asserted together with PCWrite=1 and IRWrite=1 -> pc=RESET_PC, ir=0, instr_count=0 on that edge.

Source files
------------

// File: rtl/pc_ir_unit.sv
// Program counter, instruction register and datapath latches for a multicycle
// MIPS-style core. This block holds the PC, IR, MDR, A/B operand registers,
// ALUOut, the branch-taken pulse and the fetched-instruction counter. Every
// output is registered except opcode, which is a slice of ir.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        PCSource1,
  input  logic        PCSource0,
  input  logic        IRWrite,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [31:0] mdr,
  output logic [31:0] alu_out,
  output logic [31:0] a_reg,
  output logic [31:0] b_reg,
  output logic        branch_taken,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic [31:0] alu_out_q;
  logic [31:0] a_q, b_q;
  logic        branch_taken_q;
  logic [31:0] instr_count_q;

  logic        branch_cond;
  logic        pc_load;
  logic [1:0]  pc_src;

  assign pc_src = {PCSource1, PCSource0};

  // Branch condition decoded from the instruction currently held in ir (pre-edge).
  always_comb begin
    branch_cond = 1'b0;
    if (ir_q[31:26] == OpBeq) begin
      branch_cond = alu_zero;
    end else if (ir_q[31:26] == OpBne) begin
      branch_cond = ~alu_zero;
    end
  end

  // An unconditional write wins over the branch condition.
  assign pc_load = PCWrite | (PCWriteCond & branch_cond);

  // Next-PC mux; the jump target takes the upper nibble of the already-advanced pc.
  always_comb begin
    pc_d = pc_q;
    unique case (pc_src)
      2'b00:   pc_d = alu_result;
      2'b01:   pc_d = alu_out_q;
      2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_d = pc_q;
    endcase
  end

  // State update; reset overrides every pending load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      mdr_q          <= '0;
      alu_out_q      <= '0;
      a_q            <= '0;
      b_q            <= '0;
      branch_taken_q <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      if (pc_load) begin
        pc_q <= pc_d;
      end
      if (IRWrite) begin
        ir_q          <= mem_rdata;
        instr_count_q <= instr_count_q + 32'd1;
      end
      mdr_q          <= mem_rdata;
      alu_out_q      <= alu_result;
      a_q            <= rs_data;
      b_q            <= rt_data;
      branch_taken_q <= PCWriteCond & ~PCWrite & branch_cond;
    end
  end

  assign pc           = pc_q;
  assign ir           = ir_q;
  assign opcode       = ir_q[31:26];
  assign mdr          = mdr_q;
  assign alu_out      = alu_out_q;
  assign a_reg        = a_q;
  assign b_reg        = b_q;
  assign branch_taken = branch_taken_q;
  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: each cycle's stimulus pushes the expected
// post-edge state onto a scoreboard queue, which is popped and compared just
// after the rising edge.
module tb_pc_ir_unit;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, PCWriteCond, PCSource1, PCSource0, IRWrite;
  logic [31:0] mem_rdata, alu_result, rs_data, rt_data;
  logic        alu_zero;
  logic [31:0] pc, ir, mdr, alu_out, a_reg, b_reg, instr_count;
  logic [5:0]  opcode;
  logic        branch_taken;

  pc_ir_unit #(.RESET_PC(RstPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .PCSource1    (PCSource1),
    .PCSource0    (PCSource0),
    .IRWrite      (IRWrite),
    .mem_rdata    (mem_rdata),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .pc           (pc),
    .ir           (ir),
    .opcode       (opcode),
    .mdr          (mdr),
    .alu_out      (alu_out),
    .a_reg        (a_reg),
    .b_reg        (b_reg),
    .branch_taken (branch_taken),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] cnt;
    logic [31:0] mdr;
    logic [31:0] alu_out;
    logic [31:0] a;
    logic [31:0] b;
    logic        bt;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ir, m_cnt, m_mdr, m_aluo, m_a, m_b;
  logic        m_bt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic pcw, input logic pcwc,
                      input logic [1:0] src, input logic irw, input logic [31:0] mem,
                      input logic [31:0] alu, input logic zero,
                      input logic [31:0] rs, input logic [31:0] rt);
    logic        cond;
    logic [31:0] nxt;
    exp_t        e;
    exp_t        g;
    @(negedge clk);
    rst = r; PCWrite = pcw; PCWriteCond = pcwc; {PCSource1, PCSource0} = src;
    IRWrite = irw; mem_rdata = mem; alu_result = alu; alu_zero = zero;
    rs_data = rs; rt_data = rt;
    // Model the edge using pre-edge ir/pc
    if (r) begin
      m_pc = RstPc; m_ir = '0; m_cnt = '0; m_mdr = '0; m_aluo = '0;
      m_a = '0; m_b = '0; m_bt = 1'b0;
    end else begin
      cond = (m_ir[31:26] == 6'd4) ? zero : (m_ir[31:26] == 6'd5) ? ~zero : 1'b0;
      case (src)
        2'd0:    nxt = alu;
        2'd1:    nxt = m_aluo;
        2'd2:    nxt = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: nxt = m_pc;
      endcase
      if (pcw || (pcwc && cond)) m_pc = nxt;
      if (irw) begin
        m_ir  = mem;
        m_cnt = m_cnt + 32'd1;
      end
      m_bt = pcwc & ~pcw & cond;
      m_mdr = mem; m_aluo = alu; m_a = rs; m_b = rt;
    end
    e.tag = tag; e.pc = m_pc; e.ir = m_ir; e.cnt = m_cnt; e.mdr = m_mdr;
    e.alu_out = m_aluo; e.a = m_a; e.b = m_b; e.bt = m_bt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({g.tag, ".pc"},      pc,                   g.pc);
    check({g.tag, ".ir"},      ir,                   g.ir);
    check({g.tag, ".opcode"},  {26'd0, opcode},      {26'd0, g.ir[31:26]});
    check({g.tag, ".cnt"},     instr_count,          g.cnt);
    check({g.tag, ".mdr"},     mdr,                  g.mdr);
    check({g.tag, ".alu_out"}, alu_out,              g.alu_out);
    check({g.tag, ".a"},       a_reg,                g.a);
    check({g.tag, ".b"},       b_reg,                g.b);
    check({g.tag, ".bt"},      {31'd0, branch_taken}, {31'd0, g.bt});
  endtask

  initial begin
    rst = 1'b1; PCWrite = 0; PCWriteCond = 0; PCSource1 = 0; PCSource0 = 0;
    IRWrite = 0; mem_rdata = '0; alu_result = '0; alu_zero = 0; rs_data = '0; rt_data = '0;
    m_pc = '0; m_ir = '0; m_cnt = '0; m_mdr = '0; m_aluo = '0; m_a = '0; m_b = '0; m_bt = 0;

    step("reset",     1, 0, 0, 2'b00, 0, 32'h0,         32'h0,  0, 32'h0, 32'h0);
    step("rst_prio",  1, 1, 0, 2'b00, 1, 32'hDEAD_BEEF, 32'h8,  0, 32'h1, 32'h2);
    check("rst_prio.pc_const", pc, RstPc);
    step("fetch",     0, 1, 0, 2'b00, 1, 32'h2009_0005, 32'h4,  0, 32'h11, 32'h22);
    check("fetch.pc_const", pc, 32'h4);
    check("fetch.ir_const", ir, 32'h2009_0005);
    check("fetch.cnt_const", instr_count, 32'd1);
    // Load a beq and leave 0x40 in alu_out
    step("ld_beq",    0, 0, 0, 2'b00, 1, 32'h1000_0003, 32'h40, 0, 32'h3, 32'h4);
    step("beq_take",  0, 0, 1, 2'b01, 0, 32'h0,         32'h40, 1, 32'h0, 32'h0);
    check("beq_take.pc_const", pc, 32'h40);
    step("bt_clear",  0, 0, 0, 2'b11, 0, 32'h0,         32'h80, 0, 32'h0, 32'h0);
    step("beq_not",   0, 0, 1, 2'b01, 0, 32'h0,         32'h90, 0, 32'h0, 32'h0);
    step("ld_bne",    0, 0, 0, 2'b00, 1, 32'h1400_0002, 32'h100, 0, 32'h5, 32'h6);
    step("bne_take",  0, 0, 1, 2'b01, 0, 32'h0,         32'h0,  0, 32'h0, 32'h0);
    step("bne_not",   0, 0, 1, 2'b01, 0, 32'h0,         32'h0,  1, 32'h0, 32'h0);
    step("ld_lw",     0, 0, 0, 2'b00, 1, 32'h8C00_0004, 32'h200, 0, 32'h0, 32'h0);
    step("lw_cond",   0, 0, 1, 2'b01, 0, 32'h0,         32'h0,  1, 32'h0, 32'h0);
    step("lw_cond0",  0, 0, 1, 2'b01, 0, 32'h0,         32'h0,  0, 32'h0, 32'h0);
    // Fetch the jump and advance pc to 0x1000_0004 in one edge
    step("ld_j",      0, 1, 0, 2'b00, 1, 32'h0800_0010, 32'h1000_0004, 0, 32'h0, 32'h0);
    step("jump",      0, 1, 0, 2'b10, 0, 32'h0,         32'h0,  0, 32'h0, 32'h0);
    check("jump.pc_const", pc, 32'h1000_0040);
    // Jump with simultaneous IR load: target comes from the old ir
    step("jump_irw",  0, 1, 0, 2'b10, 1, 32'h0800_0100, 32'h0,  0, 32'h0, 32'h0);
    check("jump_irw.pc_const", pc, 32'h1000_0040);
    step("src11_hold", 0, 1, 0, 2'b11, 0, 32'h0,        32'h7777, 0, 32'h0, 32'h0);
    step("ld_beq2",   0, 0, 0, 2'b00, 1, 32'h1000_0000, 32'h500, 0, 32'h0, 32'h0);
    step("both_wr",   0, 1, 1, 2'b00, 0, 32'h0,         32'h600, 0, 32'h0, 32'h0);
    step("both_wr_z", 0, 1, 1, 2'b00, 0, 32'h0,         32'h700, 1, 32'h0, 32'h0);

    // Counter wrap: preset the counter, then fetch once
    @(negedge clk);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    m_cnt = 32'hFFFF_FFFF;
    check("preset.cnt", instr_count, 32'hFFFF_FFFF);
    step("cnt_wrap",  0, 0, 0, 2'b11, 1, 32'h0000_0001, 32'h0,  0, 32'h0, 32'h0);
    check("cnt_wrap.cnt_const", instr_count, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] mem;
      mem = $urandom;
      // Bias opcodes toward beq/bne so branches get exercised
      if ($urandom_range(0, 1) == 1) mem[31:26] = ($urandom_range(0, 1) == 1) ? 6'd4 : 6'd5;
      step("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           mem, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    step("rst_mid",   1, 1, 1, 2'b00, 1, 32'h1234_5678, 32'h9,  1, 32'h1, 32'h1);
    step("after_rst", 0, 1, 0, 2'b00, 1, 32'hABCD_0001, 32'h4,  0, 32'h2, 32'h3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
